// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters sharing one datapath.
// The grant is held while the owner keeps its request high. On release,
// the search starts just after the last owner, so the next grant is issued
// with no idle gap.
//
// Optional feature (macro ARB_TIMEOUT_EN): the hold-time limit HOLD_MAX
// forces a release after HOLD_MAX consecutive cycles of one owner, and
// to_pulse flags that forced release for one cycle.
//
// state  | meaning
// S_IDLE | no grant active; searching all 8 requesters after r_last
// S_GRANT| r_idx owns the resource; gnt is the one-hot decode of r_idx
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       to_pulse
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [2:0] r_last, w_last_nxt;
  logic       r_vld, w_vld_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [3:0] w_scan_all;
  logic [3:0] w_scan_rel;

  // Returns {found, index}: first requester after f_after, wrapping modulo 8.
  // f_after itself is examined last, and only when f_incl_after is set.
  function automatic logic [3:0] f_scan(input logic [7:0] f_req,
                                        input logic [2:0] f_after,
                                        input logic       f_incl_after);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'b0000;
    // Walk from the far end back toward f_after+1 so the nearest hit wins.
    for (int i = 8; i >= 1; i--) begin
      cand = f_after + 3'(i);
      if (f_req[cand] && ((i < 8) || f_incl_after)) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  assign w_scan_all = f_scan(req, r_last, 1'b1);
  // While granted, r_last equals the current owner, so excluding it drops the
  // owner from the release search.
  assign w_scan_rel = f_scan(req, r_last, 1'b0);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TC = 8'(HOLD_MAX - 1);

  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_to, w_to_nxt;
  logic [3:0] w_scan_to;

  // A forced release also considers the current owner, placed last.
  assign w_scan_to = f_scan(req, r_idx, 1'b1);
  assign to_pulse  = r_to;
`else
  logic w_unused_hold;

  // The hold limit only matters when the timeout is built.
  assign w_unused_hold = ^(8'(HOLD_MAX));
  assign to_pulse      = 1'b0;
`endif

  // Next-state and next-output decision for both FSM states.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_vld_nxt   = r_vld;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_scan_all[3]) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_scan_all[2:0];
          w_last_nxt  = w_scan_all[2:0];
          w_vld_nxt   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt   = 8'd0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[r_idx]) begin
          if (w_scan_rel[3]) begin
            w_idx_nxt  = w_scan_rel[2:0];
            w_last_nxt = w_scan_rel[2:0];
          end else begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 3'd0;
            w_vld_nxt   = 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt = 8'd0;
        end else if (r_cnt == LP_TC) begin
          // The owner is always a candidate here, so a winner is guaranteed.
          w_idx_nxt  = w_scan_to[2:0];
          w_last_nxt = w_scan_to[2:0];
          w_cnt_nxt  = 8'd0;
          w_to_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
`endif
        end
      end
    endcase
    w_gnt_nxt = w_vld_nxt ? (8'b0000_0001 << w_idx_nxt) : 8'h00;
  end

  // State and registered outputs; reset starts with requester 0 on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_last  <= 3'd7;
      r_vld   <= 1'b0;
      r_gnt   <= 8'h00;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= 8'd0;
      r_to    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_vld   <= w_vld_nxt;
      r_gnt   <= w_gnt_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
`endif
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random request traffic,
// all compared cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       to_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner (-1 when idle), last owner, hold count, timeout flag.
  int m_owner;
  int m_last;
  int m_cnt;
  int m_to;

  rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .to_pulse(to_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester among the n positions following 'after', wrapping.
  function automatic int scan(input logic [7:0] r, input int after, input int n);
    for (int k = 1; k <= n; k++) begin
      if (r[(after + k) % 8]) return (after + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 7;
    m_cnt   = 0;
    m_to    = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    int w;
    m_to = 0;
    if (m_owner < 0) begin
      w = scan(r, m_last, 8);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
      end
    end else if (!r[m_owner]) begin
      w = scan(r, m_last, 7);
      m_owner = w;
      if (w >= 0) m_last = w;
      m_cnt = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == HM - 1) begin
        w = scan(r, m_owner, 8);
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
        m_to    = 1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".gnt"}, 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".idx"}, 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".vld"}, 32'(gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
    check({tag, ".to"}, 32'(to_pulse), 32'(m_to));
  endtask

  // One clock: DUT and model both consume the current req, then compare.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(req);
    #1;
    cmp_model(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".gnt0"}, 32'(gnt), 32'd0);
    cmp_model(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int e;
    model_reset();
    rst = 1'b1;
    req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("t1_rst_gnt", 32'(gnt), 32'h00);
    check("t1_rst_idx", 32'(gnt_idx), 32'd0);
    check("t1_rst_vld", 32'(gnt_vld), 32'd0);
    check("t1_rst_to", 32'(to_pulse), 32'd0);
    rst = 1'b0;
    cycle("t1");
    check("t1_first", 32'(gnt), 32'h01);

    // T2: full rotation, owner drops for one cycle, no idle gap.
    e = 0;
    for (int g = 0; g < 16; g++) begin
      req = 8'hFF & ~(8'h01 << e);
      cycle("t2_rel");
      e = (e + 1) % 8;
      check("t2_order", 32'(gnt), 32'd1 << e);
      req = 8'hFF;
      cycle("t2_hold");
    end

    // T3: owner 7 releases with {0,3} pending -> 0, then 3.
    req = 8'h80;
    cycle("t3_to7");
    req = 8'h89;
    cycle("t3_hold7");
    check("t3_own7", 32'(gnt), 32'h80);
    req = 8'h09;
    cycle("t3_wrap");
    check("t3_wrap0", 32'(gnt), 32'h01);
    req = 8'h08;
    cycle("t3_next");
    check("t3_next3", 32'(gnt), 32'h08);
    req = 8'h00;
    cycle("t3_idle");

    // T4: grant 2 held 50 cycles while 1 waits, then release to 1.
    req = 8'h04;
    cycle("t4_get2");
    req = 8'h06;
    for (int i = 0; i < 50; i++) begin
      cycle("t4_hold");
`ifndef ARB_TIMEOUT_EN
      check("t4_held", 32'(gnt), 32'h04);
`endif
    end
    req = 8'h02;
    cycle("t4_rel");
`ifndef ARB_TIMEOUT_EN
    check("t4_to1", 32'(gnt), 32'h02);
`endif
    req = 8'h00;
    cycle("t4_idle");

    // T5: three-cycle pulse on requester 4.
    req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      cycle("t5_on");
      check("t5_gnt", 32'(gnt), 32'h10);
    end
    req = 8'h00;
    cycle("t5_off");
    check("t5_idle", 32'(gnt), 32'h00);

    // Reset mid-grant: pointer back to 7, so 0 wins first again.
    req = 8'hFF;
    cycle("rst_pre");
    cycle("rst_pre");
    mid_reset("rst_mid");
    cycle("rst_post");
    check("rst_post0", 32'(gnt), 32'h01);

`ifdef ARB_TIMEOUT_EN
    // T6: forced rotation between 0 and 1, then sole requester regrant.
    mid_reset("t6_rst");
    req = 8'h03;
    for (int i = 0; i < 20; i++) cycle("t6_pair");
    req = 8'h01;
    for (int i = 0; i < 16; i++) cycle("t6_solo");
`endif

    // Random traffic with occasional owner drops and async resets.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 4))
        0: req = 8'($urandom);
        1: req = req;
        2: if (m_owner >= 0) req = req & ~(8'h01 << m_owner);
        3: req = 8'($urandom) & 8'($urandom);
        default: req = req | (8'h01 << $urandom_range(0, 7));
      endcase
      cycle("rnd");
      if ($urandom_range(0, 299) == 0) mid_reset("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
